// File: rtl/rs232_pkg.sv
// rs232_pkg: state encoding and line constants shared by the RS232 transmit/receive path
package rs232_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rs232_state_e;
  localparam int BIT_CNT_W = 16;
  localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/rs232_send_if.sv
// rs232_send_if: byte-stream valid/ready handshake from a producer into the transmitter
interface rs232_send_if;
  logic [7:0] I_Data;
  logic       I_Valid;
  logic       O_Ready;
  modport master(output I_Data, output I_Valid, input O_Ready);
  modport slave(input I_Data, input I_Valid, output O_Ready);
endinterface

// File: rtl/rs232_baud_tick.sv
// rs232_baud_tick: enable-gated bit-period counter, pulses on the last cycle of each bit
module rs232_baud_tick import rs232_pkg::*; #(
  parameter int P_BPS_CNT = 10
) (
  input  logic I_Clk,
  input  logic I_Rst_N,
  input  logic I_En,
  output logic O_Tick
);
  logic [BIT_CNT_W-1:0] cnt;
  assign O_Tick = I_En && cnt == BIT_CNT_W'(P_BPS_CNT - 1);
  always_ff @(posedge I_Clk or negedge I_Rst_N)
    if (!I_Rst_N) cnt <= '0;
    else cnt <= (!I_En || O_Tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rs232_send.sv
// rs232_send: 8N1/8N2 UART transmitter with a one-entry holding register.
// Define RS232_TX_PARITY_EN to insert a parity bit (even, or odd with P_PARITY_ODD=1).
module rs232_send import rs232_pkg::*; #(
  parameter int P_CLK_FREQ   = 50_000_000,
  parameter int P_RS232_BPS  = 115200,
  parameter int P_STOP_BITS  = 1,
  parameter bit P_PARITY_ODD = 1'b0
) (
  input  logic I_Clk,
  input  logic I_Rst_N,
  rs232_send_if.slave bus,
  output logic O_Txd,
  output logic O_Busy,
  output logic O_Done
);
  localparam int P_BPS_CNT = P_CLK_FREQ / P_RS232_BPS;
  if (P_STOP_BITS != 1 && P_STOP_BITS != 2) begin : g_bad_stop
    $error("rs232_send: P_STOP_BITS must be 1 or 2");
  end
  if (P_BPS_CNT < 2 || P_BPS_CNT > 65535) begin : g_bad_bps
    $error("rs232_send: bit period out of range");
  end
  rs232_state_e state, state_n;
  logic [7:0] hold, shift;
  logic [2:0] bit_idx;
  logic hold_full, accept, load, tick, last_stop, txd_n, done_n;
`ifdef RS232_TX_PARITY_EN
  localparam rs232_state_e AFTER_DATA = PARITY;
  logic parity;
  always_ff @(posedge I_Clk or negedge I_Rst_N)
    if (!I_Rst_N) parity <= 1'b0;
    else if (load) parity <= ^hold ^ P_PARITY_ODD;
`else
  localparam rs232_state_e AFTER_DATA = STOP;
  logic unused_par;
  assign unused_par = P_PARITY_ODD;
`endif
  rs232_baud_tick #(.P_BPS_CNT(P_BPS_CNT)) u_tick (
    .I_Clk  (I_Clk),
    .I_Rst_N(I_Rst_N),
    .I_En   (state != IDLE),
    .O_Tick (tick)
  );
  assign bus.O_Ready = !hold_full;
  assign accept = bus.I_Valid && !hold_full;
  assign O_Busy = state != IDLE || hold_full;
  assign last_stop = tick && bit_idx == 3'(P_STOP_BITS - 1);
  always_comb begin
    state_n = state;
    txd_n = LINE_IDLE;
    done_n = 1'b0;
    case (state)
      IDLE: state_n = hold_full ? START : IDLE;
      START: begin
        txd_n = 1'b0;
        state_n = tick ? DATA : START;
      end
      DATA: begin
        txd_n = shift[0];
        state_n = (tick && bit_idx == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef RS232_TX_PARITY_EN
      PARITY: begin
        txd_n = parity;
        state_n = tick ? STOP : PARITY;
      end
`endif
      STOP: begin
        done_n = last_stop;
        state_n = last_stop ? (hold_full ? START : IDLE) : STOP;
      end
      default: state_n = IDLE;
    endcase
    // entering START from IDLE or straight out of STOP both pull the held byte in
    load = state_n == START && state != START;
  end
  always_ff @(posedge I_Clk or negedge I_Rst_N)
    if (!I_Rst_N) begin
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      shift <= '0;
      bit_idx <= '0;
      O_Txd <= LINE_IDLE;
      O_Done <= 1'b0;
    end else begin
      state <= state_n;
      hold_full <= load ? 1'b0 : accept ? 1'b1 : hold_full;
      if (accept) hold <= bus.I_Data;
      shift <= load ? hold : (state == DATA && tick) ? shift >> 1 : shift;
      bit_idx <= state_n != state ? '0 : tick ? bit_idx + 1'b1 : bit_idx;
      O_Txd <= txd_n;
      O_Done <= done_n;
    end
endmodule

// File: tb/tb_rs232_send.sv
// tb_rs232_send: directed checks of rs232_send at a 10-cycle bit period
module tb_rs232_send;
`ifdef RS232_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  localparam int FL = (10 + int'(PEN)) * 10;
  logic I_Clk = 1'b0;
  logic I_Rst_N = 1'b0;
  always #5 I_Clk = ~I_Clk;
  rs232_send_if ifa();
  rs232_send_if ifb();
  rs232_send_if ifc();
  logic [2:0] vld = '0;
  logic [7:0] dat [3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] txd, done, busy, rdy;
  assign ifa.I_Valid = vld[0];
  assign ifb.I_Valid = vld[1];
  assign ifc.I_Valid = vld[2];
  assign ifa.I_Data = dat[0];
  assign ifb.I_Data = dat[1];
  assign ifc.I_Data = dat[2];
  assign rdy = {ifc.O_Ready, ifb.O_Ready, ifa.O_Ready};
  rs232_send #(.P_CLK_FREQ(1_000_000), .P_RS232_BPS(100_000)) u_a (
    .I_Clk(I_Clk), .I_Rst_N(I_Rst_N), .bus(ifa.slave),
    .O_Txd(txd[0]), .O_Busy(busy[0]), .O_Done(done[0]));
  rs232_send #(.P_CLK_FREQ(1_000_000), .P_RS232_BPS(100_000), .P_STOP_BITS(2)) u_b (
    .I_Clk(I_Clk), .I_Rst_N(I_Rst_N), .bus(ifb.slave),
    .O_Txd(txd[1]), .O_Busy(busy[1]), .O_Done(done[1]));
  rs232_send #(.P_CLK_FREQ(1_000_000), .P_RS232_BPS(100_000), .P_PARITY_ODD(1'b1)) u_c (
    .I_Clk(I_Clk), .I_Rst_N(I_Rst_N), .bus(ifc.slave),
    .O_Txd(txd[2]), .O_Busy(busy[2]), .O_Done(done[2]));
  int total = 0, bad = 0, acc = 0, dcnt = 0, a0, d0;
  always @(posedge I_Clk) if (vld[0] && rdy[0]) acc++;
  always @(posedge I_Clk) if (done[0]) dcnt++;
  task automatic step();
    @(posedge I_Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  // checks every cycle of one frame starting at the current (start-bit) cycle; ends on the done cycle
  task automatic frame(input int s, input logic [7:0] b, input int nstop, input logic podd, input string tag);
    logic [11:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (PEN) bits[9] = ^b ^ podd;
    n = 9 + int'(PEN) + nstop;
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("%s txd b%0d c%0d", tag, i, c), {15'd0, txd[s]}, {15'd0, bits[i]});
        chk($sformatf("%s done b%0d c%0d", tag, i, c), {15'd0, done[s]}, {15'd0, i == n - 1 && c == 9});
        if (!(i == n - 1 && c == 9)) step();
      end
  endtask
  initial begin
    step();
    chk("rst txd", {13'd0, txd}, 16'h7);
    chk("rst rdy", {13'd0, rdy}, 16'h7);
    chk("rst busy", {13'd0, busy}, 16'h0);
    chk("rst done", {13'd0, done}, 16'h0);
    I_Rst_N = 1'b1;
    step();
    // single byte, accept at edge 0
    dat[0] = 8'hA5; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    chk("t1 c0 rdy", {15'd0, rdy[0]}, 16'd0);
    chk("t1 c0 busy", {15'd0, busy[0]}, 16'd1);
    step();
    chk("t1 c1 txd", {15'd0, txd[0]}, 16'd1);
    chk("t1 c1 rdy", {15'd0, rdy[0]}, 16'd1);
    step();
    frame(0, 8'hA5, 1, 1'b0, "t1");
    step();
    chk("t1 end busy", {15'd0, busy[0]}, 16'd0);
    chk("t1 end txd", {15'd0, txd[0]}, 16'd1);
    chk("t1 end done", {15'd0, done[0]}, 16'd0);
    step();
    // back-to-back frames with the second byte queued in the holding register
    dat[0] = 8'h00; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    chk("t2 c0 rdy", {15'd0, rdy[0]}, 16'd0);
    step();
    chk("t2 c1 rdy", {15'd0, rdy[0]}, 16'd1);
    dat[0] = 8'hFF; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    chk("t2 c2 rdy", {15'd0, rdy[0]}, 16'd0);
    frame(0, 8'h00, 1, 1'b0, "t2a");
    chk("t2 reload rdy", {15'd0, rdy[0]}, 16'd1);
    step();
    frame(0, 8'hFF, 1, 1'b0, "t2b");
    step();
    chk("t2 end busy", {15'd0, busy[0]}, 16'd0);
    step();
    // valid held high: exactly three handshakes give exactly three frames
    a0 = acc; d0 = dcnt;
    dat[0] = 8'h3C; vld[0] = 1'b1;
    for (int k = 0; k <= 3 * FL + 1; k++) begin
      step();
      if (acc - a0 == 3) vld[0] = 1'b0;
    end
    chk("t3 last done", {15'd0, done[0]}, 16'd1);
    step();
    chk("t3 accepts", 16'(acc - a0), 16'd3);
    chk("t3 dones", 16'(dcnt - d0), 16'd3);
    chk("t3 end busy", {15'd0, busy[0]}, 16'd0);
    // reset in the middle of a frame drops the frame and the held byte
    dat[0] = 8'h55; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    step();
    dat[0] = 8'h99; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    chk("t4 held rdy", {15'd0, rdy[0]}, 16'd0);
    for (int k = 3; k <= 45; k++) step();
    chk("t4 c45 txd", {15'd0, txd[0]}, 16'd0);
    d0 = dcnt;
    I_Rst_N = 1'b0;
    #1;
    chk("t4 async txd", {15'd0, txd[0]}, 16'd1);
    chk("t4 async busy", {15'd0, busy[0]}, 16'd0);
    chk("t4 async rdy", {15'd0, rdy[0]}, 16'd1);
    step(); step();
    I_Rst_N = 1'b1;
    for (int k = 0; k < 150; k++) begin
      step();
      chk($sformatf("t4 idle txd %0d", k), {15'd0, txd[0]}, 16'd1);
      chk($sformatf("t4 idle busy %0d", k), {15'd0, busy[0]}, 16'd0);
    end
    chk("t4 no done", 16'(dcnt - d0), 16'd0);
    dat[0] = 8'h81; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    step(); step();
    frame(0, 8'h81, 1, 1'b0, "t4");
    step();
    // two stop bits
    dat[1] = 8'h01; vld[1] = 1'b1;
    step();
    vld[1] = 1'b0;
    step(); step();
    frame(1, 8'h01, 2, 1'b0, "t5");
    step();
    chk("t5 end busy", {15'd0, busy[1]}, 16'd0);
    // parity sense (even on u_a, odd on u_c)
    dat[0] = 8'h07; vld[0] = 1'b1;
    dat[2] = 8'h07; vld[2] = 1'b1;
    step();
    vld[0] = 1'b0; vld[2] = 1'b0;
    step(); step();
    fork
      frame(0, 8'h07, 1, 1'b0, "t6e");
      frame(2, 8'h07, 1, 1'b1, "t6o");
    join
    step();
    chk("t6 end busy", {14'd0, busy[2], busy[0]}, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
